// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with hardware return-address stack
//
// Purpose:
//   Program counter for the basic processor. Besides plain increment and
//   load from the shared bus it supports subroutine CALL (push the return
//   address count+1 and jump to the bus address) and RET (pop the return
//   address into count). Overflow, underflow and CALL/RET conflicts set a
//   sticky error flag that only reset clears.
//
// Parameters:
//   WORD_W  - system bus width in bits
//   OP_W    - opcode field width; the address width is WORD_W-OP_W
//   STACK_D - return-stack depth in entries (power of 2, >= 2)
//
// Ports:
//   clock     in     system clock, rising edge active
//   n_reset   in     asynchronous active-low reset
//   PC_bus    in     drive {zeros, count} onto sysbus
//   load_PC   in     update count (increment or load from sysbus)
//   INC_PC    in     with load_PC: increment instead of load
//   CALL      in     push count+1, load count from sysbus
//   RET       in     pop top of stack into count
//   sysbus    inout  shared tri-state system bus
//   sp_empty  out    stack holds no entries
//   sp_full   out    stack holds STACK_D entries
//   stack_err out    sticky overflow / underflow / conflict flag

module pc_stack #(
  parameter int WORD_W  = 8,
  parameter int OP_W    = 3,
  parameter int STACK_D = 4
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              PC_bus,
  input  logic              load_PC,
  input  logic              INC_PC,
  input  logic              CALL,
  input  logic              RET,
  inout  wire  [WORD_W-1:0] sysbus,
  output logic              sp_empty,
  output logic              sp_full,
  output logic              stack_err
);

  localparam int ADDR_W = WORD_W - OP_W;
  localparam int IDX_W  = $clog2(STACK_D);
  // sp counts 0..STACK_D inclusive, so it needs one bit more than an index.
  localparam int SP_W   = IDX_W + 1;

  logic [ADDR_W-1:0] count_q, count_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_D];
  logic [ADDR_W-1:0] stack_d [STACK_D];

  logic [ADDR_W-1:0] bus_addr;
  logic [ADDR_W-1:0] count_inc;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              unused_opcode;

  // Opcode bits of the bus are not part of an address.
  assign bus_addr      = sysbus[ADDR_W-1:0];
  assign unused_opcode = ^sysbus[WORD_W-1:ADDR_W];

  // Wraps naturally from 2^ADDR_W-1 to 0; also the CALL return address.
  assign count_inc = count_q + 1'b1;

  // Push index is sp itself (only used when not full, so the top bit is 0).
  // Pop index is sp-1 taken modulo STACK_D: when sp==STACK_D the low bits
  // are zero and the subtraction wraps to STACK_D-1, which is the top entry.
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = sp_q[IDX_W-1:0] - 1'b1;

  assign sp_empty  = (sp_q == '0);
  assign sp_full   = (sp_q == SP_W'(STACK_D));
  assign stack_err = err_q;

  // Only this block ever drives the bus, and only while PC_bus is high.
  // A self-load (PC_bus with a load or CALL) just feeds count_q back through
  // bus_addr into count_d; there is no combinational loop through the flops.
  assign sysbus = PC_bus ? {{OP_W{1'b0}}, count_q} : {WORD_W{1'bz}};

  always_comb begin
    count_d = count_q;
    sp_d    = sp_q;
    err_d   = err_q;
    for (int i = 0; i < STACK_D; i++) begin
      stack_d[i] = stack_q[i];
    end

    if (CALL && RET) begin
      // Conflicting requests: leave count and stack untouched.
      err_d = 1'b1;
    end else if (CALL) begin
      // The jump always happens; only the push is dropped on overflow.
      count_d = bus_addr;
      if (!sp_full) begin
        stack_d[push_idx] = count_inc;
        sp_d              = sp_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (RET) begin
      if (!sp_empty) begin
        count_d = stack_q[pop_idx];
        sp_d    = sp_q - 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (load_PC) begin
      count_d = INC_PC ? count_inc : bus_addr;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_D; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      for (int i = 0; i < STACK_D; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - self-checking bench for pc_stack

module tb_pc_stack;

  logic clock = 1'b0;
  logic n_reset = 1'b0;

  // Default-parameter instance (8-bit bus, 5-bit address, depth 4)
  logic       pc_bus, load_pc, inc_pc, call, ret;
  logic       drv_en;
  logic [7:0] drv;
  wire  [7:0] bus8;
  wire        n_empty, n_full, n_err;

  // Wide instance (16-bit bus, 12-bit address, depth 8)
  logic        w_pc_bus, w_load_pc, w_inc_pc, w_call, w_ret;
  logic        w_drv_en;
  logic [15:0] w_drv;
  wire  [15:0] bus16;
  wire         w_empty, w_full, w_err;

  int checks = 0;
  int errors = 0;

  assign bus8  = drv_en   ? drv   : 8'hzz;
  assign bus16 = w_drv_en ? w_drv : 16'hzzzz;

  pc_stack u_dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .PC_bus    (pc_bus),
    .load_PC   (load_pc),
    .INC_PC    (inc_pc),
    .CALL      (call),
    .RET       (ret),
    .sysbus    (bus8),
    .sp_empty  (n_empty),
    .sp_full   (n_full),
    .stack_err (n_err)
  );

  pc_stack #(.WORD_W(16), .OP_W(4), .STACK_D(8)) u_dut_w (
    .clock     (clock),
    .n_reset   (n_reset),
    .PC_bus    (w_pc_bus),
    .load_PC   (w_load_pc),
    .INC_PC    (w_inc_pc),
    .CALL      (w_call),
    .RET       (w_ret),
    .sysbus    (bus16),
    .sp_empty  (w_empty),
    .sp_full   (w_full),
    .stack_err (w_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       c;
    logic       r;
    logic       l;
    logic       i;
    logic [7:0] bus;
    logic [4:0] cnt;
    logic       empty;
    logic       full;
    logic       err;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_v(input int k, input logic c, input logic r, input logic l, input logic i,
                       input logic [7:0] b, input logic [4:0] cnt,
                       input logic e, input logic f, input logic er);
    vecs[k].c = c; vecs[k].r = r; vecs[k].l = l; vecs[k].i = i;
    vecs[k].bus = b; vecs[k].cnt = cnt;
    vecs[k].empty = e; vecs[k].full = f; vecs[k].err = er;
  endtask

  // Apply one cycle of control on the narrow DUT, then idle it with PC_bus=1
  // so count is readable on the bus.
  task automatic step(input logic c, input logic r, input logic l, input logic i,
                      input logic [7:0] b, input logic self_bus);
    @(negedge clock);
    call = c; ret = r; load_pc = l; inc_pc = i;
    pc_bus = self_bus;
    drv    = b;
    drv_en = !self_bus && (c || (l && !i));
    @(posedge clock);
    #1;
    call = 1'b0; ret = 1'b0; load_pc = 1'b0; inc_pc = 1'b0;
    drv_en = 1'b0; pc_bus = 1'b1;
    #1;
  endtask

  task automatic w_step(input logic c, input logic r, input logic l, input logic i,
                        input logic [15:0] b);
    @(negedge clock);
    w_call = c; w_ret = r; w_load_pc = l; w_inc_pc = i;
    w_pc_bus = 1'b0;
    w_drv    = b;
    w_drv_en = c || (l && !i);
    @(posedge clock);
    #1;
    w_call = 1'b0; w_ret = 1'b0; w_load_pc = 1'b0; w_inc_pc = 1'b0;
    w_drv_en = 1'b0; w_pc_bus = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    n_reset = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pc_bus = 1'b0; load_pc = 1'b0; inc_pc = 1'b0; call = 1'b0; ret = 1'b0;
    drv_en = 1'b0; drv = 8'h00;
    w_pc_bus = 1'b0; w_load_pc = 1'b0; w_inc_pc = 1'b0; w_call = 1'b0; w_ret = 1'b0;
    w_drv_en = 1'b0; w_drv = 16'h0000;

    //            c  r  l  i  bus    cnt    e  f  err
    set_v( 0, 1'b0,1'b0,1'b1,1'b1, 8'h00, 5'd1,  1'b1,1'b0,1'b0); // increment
    set_v( 1, 1'b0,1'b0,1'b1,1'b0, 8'hE5, 5'd5,  1'b1,1'b0,1'b0); // load, opcode ignored
    set_v( 2, 1'b0,1'b0,1'b1,1'b0, 8'h03, 5'd3,  1'b1,1'b0,1'b0);
    set_v( 3, 1'b1,1'b0,1'b0,1'b0, 8'h0A, 5'd10, 1'b0,1'b0,1'b0); // push 4
    set_v( 4, 1'b1,1'b0,1'b0,1'b0, 8'h14, 5'd20, 1'b0,1'b0,1'b0); // push 11
    set_v( 5, 1'b0,1'b1,1'b0,1'b0, 8'h00, 5'd11, 1'b0,1'b0,1'b0);
    set_v( 6, 1'b0,1'b1,1'b0,1'b0, 8'h00, 5'd4,  1'b1,1'b0,1'b0);
    set_v( 7, 1'b0,1'b0,1'b0,1'b1, 8'h00, 5'd4,  1'b1,1'b0,1'b0); // INC_PC alone
    set_v( 8, 1'b0,1'b0,1'b0,1'b0, 8'h00, 5'd4,  1'b1,1'b0,1'b0); // hold
    set_v( 9, 1'b1,1'b0,1'b0,1'b0, 8'h01, 5'd1,  1'b0,1'b0,1'b0); // push 5
    set_v(10, 1'b1,1'b0,1'b0,1'b0, 8'h02, 5'd2,  1'b0,1'b0,1'b0); // push 2
    set_v(11, 1'b1,1'b0,1'b0,1'b0, 8'h03, 5'd3,  1'b0,1'b0,1'b0); // push 3
    set_v(12, 1'b1,1'b0,1'b0,1'b0, 8'h1F, 5'd31, 1'b0,1'b1,1'b0); // push 4, full
    set_v(13, 1'b1,1'b0,1'b0,1'b0, 8'h07, 5'd7,  1'b0,1'b1,1'b1); // overflow: jump only
    set_v(14, 1'b0,1'b1,1'b0,1'b0, 8'h00, 5'd4,  1'b0,1'b0,1'b1);
    set_v(15, 1'b1,1'b1,1'b0,1'b0, 8'h09, 5'd4,  1'b0,1'b0,1'b1); // conflict
    set_v(16, 1'b0,1'b0,1'b1,1'b1, 8'h00, 5'd5,  1'b0,1'b0,1'b1);
    set_v(17, 1'b0,1'b1,1'b0,1'b0, 8'h00, 5'd3,  1'b0,1'b0,1'b1);
    set_v(18, 1'b0,1'b1,1'b0,1'b0, 8'h00, 5'd2,  1'b0,1'b0,1'b1);
    set_v(19, 1'b0,1'b1,1'b0,1'b0, 8'h00, 5'd5,  1'b1,1'b0,1'b1);
    set_v(20, 1'b0,1'b1,1'b0,1'b0, 8'h00, 5'd5,  1'b1,1'b0,1'b1); // underflow
    set_v(21, 1'b0,1'b0,1'b1,1'b0, 8'hFF, 5'd31, 1'b1,1'b0,1'b1);
    set_v(22, 1'b1,1'b0,1'b0,1'b0, 8'h06, 5'd6,  1'b0,1'b0,1'b1); // return addr wraps to 0
    set_v(23, 1'b0,1'b1,1'b0,1'b0, 8'h00, 5'd0,  1'b1,1'b0,1'b1);

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset sp_empty", {15'd0, n_empty}, 16'd1);
    chk("reset sp_full", {15'd0, n_full}, 16'd0);
    chk("reset stack_err", {15'd0, n_err}, 16'd0);
    chk("wide reset sp_empty", {15'd0, w_empty}, 16'd1);
    pc_bus = 1'b1;
    #1;
    chk("reset count", {8'd0, bus8}, 16'h0000);
    n_reset = 1'b1;

    // 40 increments: 0..31 then wraps to 0..7
    @(negedge clock);
    load_pc = 1'b1; inc_pc = 1'b1; pc_bus = 1'b1;
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("inc seq %0d", k), {8'd0, bus8}, 16'(k % 32));
      @(negedge clock);
    end
    load_pc = 1'b0; inc_pc = 1'b0;
    chk("inc seq final", {8'd0, bus8}, 16'd8);
    chk("inc seq stack_err", {15'd0, n_err}, 16'd0);

    // Directed table
    do_reset();
    for (int k = 0; k < 24; k++) begin
      step(vecs[k].c, vecs[k].r, vecs[k].l, vecs[k].i, vecs[k].bus, 1'b0);
      chk($sformatf("vec%0d count", k), {8'd0, bus8}, {11'd0, vecs[k].cnt});
      chk($sformatf("vec%0d sp_empty", k), {15'd0, n_empty}, {15'd0, vecs[k].empty});
      chk($sformatf("vec%0d sp_full", k), {15'd0, n_full}, {15'd0, vecs[k].full});
      chk($sformatf("vec%0d stack_err", k), {15'd0, n_err}, {15'd0, vecs[k].err});
    end

    // Self-load: PC_bus together with load or CALL reloads count itself
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h0C, 1'b0);
    chk("selfload setup", {8'd0, bus8}, 16'h000C);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("selfload count", {8'd0, bus8}, 16'h000C);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("selfcall count", {8'd0, bus8}, 16'h000C);
    chk("selfcall sp_empty", {15'd0, n_empty}, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("selfcall return", {8'd0, bus8}, 16'h000D);
    chk("selfcall pop sp_empty", {15'd0, n_empty}, 16'd1);

    // Underflow directly after reset
    do_reset();
    chk("post reset stack_err", {15'd0, n_err}, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("underflow count held", {8'd0, bus8}, 16'h0000);
    chk("underflow stack_err", {15'd0, n_err}, 16'd1);

    // Reset asserted between edges in the middle of a CALL sequence
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h14, 1'b0);
    chk("midreset pre count", {8'd0, bus8}, 16'h0014);
    @(negedge clock);
    call = 1'b1; pc_bus = 1'b0; drv = 8'h05; drv_en = 1'b1;
    #2;
    n_reset = 1'b0;
    #1;
    call = 1'b0; drv_en = 1'b0; pc_bus = 1'b1;
    #1;
    chk("midreset sp_empty", {15'd0, n_empty}, 16'd1);
    chk("midreset stack_err", {15'd0, n_err}, 16'd0);
    chk("midreset count", {8'd0, bus8}, 16'h0000);
    @(posedge clock);
    #1;
    chk("midreset held count", {8'd0, bus8}, 16'h0000);
    @(negedge clock);
    n_reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("midreset stack emptied", {15'd0, n_err}, 16'd1);
    chk("midreset ret count", {8'd0, bus8}, 16'h0000);

    // Wide instance: address wrap at 4095 and 8-deep LIFO unwind
    w_step(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE);
    chk("wide load", bus16, 16'h0FFE);
    w_step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("wide inc 4095", bus16, 16'h0FFF);
    w_step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk("wide wrap", bus16, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      w_step(1'b1, 1'b0, 1'b0, 1'b0, 16'((k + 1) * 16'h0100));
      chk($sformatf("wide call%0d count", k), bus16, 16'((k + 1) * 16'h0100));
      chk($sformatf("wide call%0d sp_full", k), {15'd0, w_full}, {15'd0, (k == 7)});
    end
    for (int k = 0; k < 8; k++) begin
      w_step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk($sformatf("wide ret%0d count", k), bus16, 16'((7 - k) * 16'h0100 + 1));
    end
    chk("wide sp_empty", {15'd0, w_empty}, 16'd1);
    chk("wide stack_err", {15'd0, w_err}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Program counter with a hardware return-address stack for the basic processor.
- Extends plain increment/load with subroutine CALL (push return address, jump) and RET (pop).
- Width, opcode-field width and stack depth are parametrised.
- Sits on the shared tri-state system bus, as before. The controller sequencer drives PC_bus, load_PC, INC_PC, CALL and RET.

Parameters:
- WORD_W, 8, system bus width in bits.
- OP_W, 3, opcode field width. Address width ADDR_W = WORD_W-OP_W (derived, not overridable).
- STACK_D, 4, return-stack depth in entries. Must be >=2 and a power of 2.

Ports:
- clock  in  1  system clock, rising edge active.
- n_reset  in  1  asynchronous, active-low reset.
- PC_bus  in  1  drive the PC onto sysbus.
- load_PC  in  1  update PC, either increment or load from sysbus.
- INC_PC  in  1  with load_PC: increment instead of load.
- CALL  in  1  push count+1, load count from sysbus.
- RET  in  1  pop top of stack into count.
- sysbus  inout  WORD_W  shared system bus.
- sp_empty  out  1  stack holds 0 entries.
- sp_full  out  1  stack holds STACK_D entries.
- stack_err  out  1  sticky error flag: overflow, underflow or conflict.

Behaviour:
- Reset (async, n_reset=0):
  - count=0, stack pointer sp=0, all stack entries=0.
  - stack_err=0, sp_empty=1, sp_full=0.
  - sysbus follows PC_bus as below; reset does not force it.
- Bus drive (combinational):
  - sysbus = {OP_W zeros, count} when PC_bus=1, else high-Z.
  - No other output ever drives sysbus.
- Per rising edge, first match wins:
  1. CALL=1 and RET=1: conflict. count and stack unchanged; stack_err<=1.
  2. CALL=1, not full: stack[sp]<=count+1 (mod 2^ADDR_W); sp<=sp+1; count<=sysbus[ADDR_W-1:0].
  3. CALL=1, full: count<=sysbus[ADDR_W-1:0]; push dropped; sp unchanged; stack_err<=1.
  4. RET=1, not empty: count<=stack[sp-1]; sp<=sp-1.
  5. RET=1, empty: count unchanged; stack_err<=1.
  6. load_PC=1, INC_PC=1: count<=count+1, wraps from 2^ADDR_W-1 to 0.
  7. load_PC=1, INC_PC=0: count<=sysbus[ADDR_W-1:0]. The upper OP_W bits are ignored.
  8. Otherwise: hold.
- Signal interactions:
  - INC_PC without load_PC has no effect.
  - CALL and RET override load_PC and INC_PC.
- sp runs 0..STACK_D and is log2(STACK_D)+1 bits wide.
  - sp_empty = (sp==0); sp_full = (sp==STACK_D). Both are combinational from sp.
- stack_err clears only on reset.
- Latency: every update is visible on count, and on sysbus when PC_bus=1, one cycle after the enabling edge.
- Return address on CALL is count+1, i.e. the instruction after the call.
- Reset asserted mid-operation aborts any update in progress; the stack is emptied.
- PC_bus=1 together with load_PC, INC_PC=0 or with CALL loads count's own value (self-load). This is legal and must not glitch state.

Test Plan:
- Reset, then 40 cycles of load_PC=1, INC_PC=1 (defaults) -> count sequence 0..31 wraps to 0..7. stack_err=0.
- Drive sysbus=8'hE5, load_PC=1, INC_PC=0; next cycle PC_bus=1 -> sysbus reads 8'h05.
- Nested calls with count=3:
  - CALL target 10, then CALL target 20 -> sp=2, count=20.
  - RET -> count=11.
  - RET -> count=4; sp_empty=1.
- Overflow and underflow:
  - 5 CALLs with STACK_D=4 -> sp_full after the 4th; 5th jumps but stack_err=1.
  - After reset, RET on empty -> count held, stack_err=1.
- CALL and RET in the same cycle -> count and sp unchanged, stack_err=1.
- Reset asserted between edges during a CALL sequence -> count=0, sp_empty=1, stack_err=0 immediately.
- Regression with WORD_W=16, OP_W=4, STACK_D=8: wrap at 4095, and 8 nested calls unwind in LIFO order.
